prefetch_request_queue: RTL and testbench
=========================================

PREFETCH_REQUEST_QUEUE -- requirements
Module: prefetch_request_queue

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter DEPTH, default 8, power of two, SHALL set the queue entry count.
REQ-003 Parameter MAX_OUT, default 4, SHALL set the maximum number of outstanding memory requests.
REQ-004 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_addr  input  ADDR_W  SHALL carry the prefetch address from the upstream 3-D prefetcher.
REQ-007 in_valid  input  1  SHALL be the upstream one-cycle address strobe; there is no backpressure.
REQ-008 flush  input  1  SHALL discard all queued entries.
REQ-009 mem_req_valid  output  1  SHALL indicate that mem_req_addr is valid.
REQ-010 mem_req_addr  output  ADDR_W  SHALL carry the head-of-queue address.
REQ-011 mem_req_ready  input  1  SHALL be the memory-side acceptance signal.
REQ-012 mem_resp_valid  input  1  SHALL be a one-cycle completion pulse for one outstanding request.
REQ-013 empty / full  output  1 each  SHALL give the registered queue status.
REQ-014 outstanding  output  clog2(MAX_OUT+1)  SHALL give the in-flight request count.
REQ-015 drop_count / dup_count  output  16 each  SHALL be saturating event counters.

Function
REQ-016 Enqueue SHALL occur when in_valid=1, flush=0, the queue is not full and in_addr matches no valid queue entry; the entry becomes visible the next cycle.
REQ-017 Duplicate check SHALL compare in_addr against all valid entries, including the head being popped the same cycle; on a match the address is dropped and dup_count increments.
REQ-018 When full, an arriving address SHALL be dropped and drop_count incremented; full is evaluated on pre-pop occupancy, so a simultaneous pop does not admit the push.
REQ-019 If an arrival is both a duplicate and meets a full queue, it SHALL count as a duplicate only.
REQ-020 The queue SHALL be strictly FIFO with read and write pointers wrapping modulo DEPTH.
REQ-021 The issue FSM SHALL have states IDLE (queue empty), ISSUE (non-empty and outstanding<MAX_OUT) and THROTTLE (non-empty and outstanding==MAX_OUT), evaluated every cycle from registered occupancy and outstanding.
REQ-022 mem_req_valid SHALL be 1 only in ISSUE; mem_req_addr SHALL equal the head entry and stay stable while valid and not accepted.
REQ-023 Handshake fire = mem_req_valid & mem_req_ready; fire SHALL pop the head and increment outstanding.
REQ-024 outstanding SHALL decrement on mem_resp_valid; a simultaneous fire and response SHALL leave it unchanged.
REQ-025 mem_resp_valid with outstanding==0 SHALL be ignored.
REQ-026 flush SHALL empty the queue on the next edge, take priority over push, and leave outstanding unchanged; a fire in the flush cycle still counts as outstanding.
REQ-027 Counters SHALL saturate at 16'hFFFF.
REQ-028 Latency from an in_valid strobe into an empty queue to mem_req_valid SHALL be exactly one cycle.

Reset
REQ-029 On reset_n=0, asynchronously: queue empty, pointers 0, empty=1, full=0, mem_req_valid=0, mem_req_addr=0, outstanding=0, both counters 0, FSM state IDLE.
REQ-030 Reset asserted mid-operation SHALL discard all entries and in-flight accounting with no further memory requests issued.

Verification
REQ-031 Basic: strobe 0x10 with mem_req_ready=1 -> next cycle mem_req_valid=1 and addr=0x10; after fire, outstanding=1 and empty=1.
REQ-032 Dedup: strobe 0x05, 0x07, 0x05 with mem_req_ready=0 -> 2 entries, dup_count=1, issue order 0x05 then 0x07.
REQ-033 Full: mem_req_ready=0 and 10 distinct strobes, DEPTH=8 -> full=1 and drop_count=2; draining yields the first 8 addresses in order.
REQ-034 Throttle: MAX_OUT=4 with 6 queued entries and no responses -> 4 fires, then mem_req_valid=0; one mem_resp_valid -> exactly one more fire.
REQ-035 Flush/reset: flush with 3 entries and outstanding=2 -> empty=1 and outstanding=2; then reset_n=0 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/prefetch_request_queue.sv
// rtl/prefetch_request_queue.sv - deduplicating prefetch address FIFO with outstanding-request throttling
module prefetch_request_queue #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4,
  localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_valid,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  output logic              empty,
  output logic              full,
  output logic [OUT_W-1:0]  outstanding,
  output logic [15:0]       drop_count,
  output logic [15:0]       dup_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, THROTTLE} state_t;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [15:0]       drop_q, drop_d, dup_q, dup_d;
  state_t            state_q, state_d;

  logic             fire, push, dup_hit, resp_ok;
  logic [PTR_W-1:0] off;

  assign empty         = (count_q == '0);
  assign full          = (count_q == (PTR_W+1)'(DEPTH));
  assign outstanding   = out_q;
  assign drop_count    = drop_q;
  assign dup_count     = dup_q;
  assign mem_req_valid = (state_q == ISSUE);
  // Address is forced to zero when not requesting so reset leaves it at 0.
  assign mem_req_addr  = mem_req_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    fire     = mem_req_valid & mem_req_ready;
    resp_ok  = mem_resp_valid & (out_q != '0);
    dup_hit  = 1'b0;
    off      = '0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    drop_d   = drop_q;
    dup_d    = dup_q;
    state_d  = IDLE;

    // Entry i is live when its distance from the read pointer is below occupancy.
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (mem_q[i] == in_addr)) dup_hit = 1'b1;
    end

    push = in_valid & ~flush & ~dup_hit & ~full;

    if (in_valid && !flush && dup_hit && dup_q != 16'hFFFF) dup_d = dup_q + 16'd1;
    if (in_valid && !flush && !dup_hit && full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fire) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, fire};
    end

    if (fire && !resp_ok)      out_d = out_q + 1'b1;
    else if (!fire && resp_ok) out_d = out_q - 1'b1;

    if (count_d == '0)                   state_d = IDLE;
    else if (out_d < OUT_W'(MAX_OUT))    state_d = ISSUE;
    else                                 state_d = THROTTLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      dup_q    <= '0;
      state_q  <= IDLE;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      dup_q    <= dup_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_addr;
  end
endmodule

// File: tb/tb_prefetch_request_queue.sv
// tb/tb_prefetch_request_queue.sv - directed self-checking bench for prefetch_request_queue
module tb_prefetch_request_queue;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] in_addr;
  logic        in_valid, flush, mem_req_ready, mem_resp_valid;
  logic        mem_req_valid, empty, full;
  logic [31:0] mem_req_addr;
  logic [2:0]  outstanding;
  logic [15:0] drop_count, dup_count;

  int total = 0;
  int bad   = 0;

  prefetch_request_queue #(.ADDR_W(32), .DEPTH(8), .MAX_OUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_addr(in_addr), .in_valid(in_valid),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .empty(empty), .full(full), .outstanding(outstanding),
    .drop_count(drop_count), .dup_count(dup_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [31:0] a);
    in_valid = 1'b1;
    in_addr  = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_valid"}, mem_req_valid, 0);
    check({tag, "_addr"}, mem_req_addr, 0);
    check({tag, "_out"}, outstanding, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_dup"}, dup_count, 0);
  endtask

  initial begin
    reset_n = 1'b0; in_addr = '0; in_valid = 0; flush = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    #3;
    check_reset("rst");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // basic issue, one-cycle latency
    mem_req_ready = 1;
    strobe(32'h10);
    check("basic_valid", mem_req_valid, 1);
    check("basic_addr", mem_req_addr, 32'h10);
    tick();
    check("basic_out", outstanding, 1);
    check("basic_empty", empty, 1);
    check("basic_idle", mem_req_valid, 0);
    mem_resp_valid = 1; tick(); mem_resp_valid = 0;
    check("basic_resp", outstanding, 0);

    // dedup
    mem_req_ready = 0;
    strobe(32'h05); strobe(32'h07); strobe(32'h05);
    check("dedup_cnt", dup_count, 1);
    check("dedup_head", mem_req_addr, 32'h05);
    mem_req_ready = 1;
    tick();
    check("dedup_second", mem_req_addr, 32'h07);
    check("dedup_valid2", mem_req_valid, 1);
    tick();
    check("dedup_empty", empty, 1);
    check("dedup_out", outstanding, 2);
    mem_req_ready = 0;
    mem_resp_valid = 1; tick(); tick(); mem_resp_valid = 0;
    check("dedup_out0", outstanding, 0);

    // full / drop, duplicate on full counts only as duplicate
    for (int i = 0; i < 10; i++) strobe(32'h100 + i);
    check("full_flag", full, 1);
    check("full_drop", drop_count, 2);
    strobe(32'h100);
    check("full_dup", dup_count, 2);
    check("full_drop2", drop_count, 2);
    mem_req_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid%0d", i), mem_req_valid, 1);
      check($sformatf("drain_addr%0d", i), mem_req_addr, 32'h100 + i);
      tick();
    end
    mem_req_ready = 0;
    tick(); mem_resp_valid = 0;
    check("drain_empty", empty, 1);
    check("drain_notfull", full, 0);
    check("drain_out", outstanding, 0);

    // throttle at MAX_OUT
    for (int i = 0; i < 6; i++) strobe(32'h200 + i);
    mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("thr_addr%0d", i), mem_req_addr, 32'h200 + i);
      tick();
    end
    check("thr_stall", mem_req_valid, 0);
    check("thr_out", outstanding, 4);
    tick();
    check("thr_stall2", mem_req_valid, 0);
    mem_resp_valid = 1; tick(); mem_resp_valid = 0;
    check("thr_resume", mem_req_valid, 1);
    check("thr_resume_addr", mem_req_addr, 32'h204);
    tick();
    check("thr_restall", mem_req_valid, 0);
    check("thr_out4", outstanding, 4);
    check("thr_left", empty, 0);

    // flush keeps outstanding, then async reset
    mem_req_ready = 0;
    mem_resp_valid = 1; tick(); tick(); mem_resp_valid = 0;
    check("fl_out2", outstanding, 2);
    strobe(32'h300); strobe(32'h301);
    check("fl_nonempty", empty, 0);
    flush = 1; tick(); flush = 0;
    check("fl_empty", empty, 1);
    check("fl_out", outstanding, 2);
    check("fl_valid", mem_req_valid, 0);
    strobe(32'h400);
    check("fl_push_after", mem_req_addr, 32'h400);
    #2 reset_n = 1'b0;
    #1;
    check_reset("rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
